// File: rtl/simon_seq_engine.sv
// simon_seq_engine: pattern-sequence datapath for the Simon game.
// Stores a growing sequence of PAT_W-bit patterns, checks player repeats,
// and replays the sequence with a self-timed playback engine.
// Optional feature: define SIMON_SEQ_SCORE_EN to keep a best_len high-score
// register; otherwise best_len is tied to zero.
module simon_seq_engine #(
  parameter int PAT_W      = 4,
  parameter int ADDR_W     = 6,
  parameter int PLAY_TICKS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              level,
  input  logic [PAT_W-1:0]  pattern,
  input  logic              restart,
  input  logic              clear_i,
  input  logic              increment_i,
  input  logic              write_pattern,
  input  logic              input_led_pattern,
  input  logic              play_start,
  output logic              seq_remain,
  output logic              valid_repeat,
  output logic              valid_input,
  output logic              seq_full,
  output logic [ADDR_W:0]   seq_len,
  output logic              busy,
  output logic              play_done,
  output logic [ADDR_W:0]   best_len,
  output logic [PAT_W-1:0]  pattern_leds
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int TW    = (PLAY_TICKS > 1) ? $clog2(PLAY_TICKS) : 1;

  localparam logic [ADDR_W:0]   N_ONE     = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   N_DEPTH   = N_ONE << ADDR_W;
  localparam logic [ADDR_W-1:0] I_ONE     = ADDR_W'(1);
  localparam logic [TW-1:0]     T_ONE     = TW'(1);
  localparam logic [TW-1:0]     T_LAST    = TW'(PLAY_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } play_state_t;

  play_state_t          state, state_nxt;
  logic [PAT_W-1:0]     mem [DEPTH];
  logic [ADDR_W:0]      n;
  logic [ADDR_W-1:0]    i;
  logic [TW-1:0]        timer;
  logic                 level_q;

  logic                 onehot_pat;
  logic                 write_ok;
  logic                 tick_last;
  logic                 last_entry;
  logic                 start_play;
  logic [PAT_W-1:0]     mem_rd;

  // Status decode: everything here is combinational from state and inputs.
  assign mem_rd       = mem[i];
  assign onehot_pat   = (pattern != '0) && ((pattern & (pattern - 1'b1)) == '0);
  assign valid_input  = level_q | onehot_pat;
  assign seq_full     = (n == N_DEPTH);
  assign seq_len      = n;
  assign seq_remain   = ({1'b0, i} + N_ONE) < n;
  assign valid_repeat = (mem_rd == pattern);
  assign pattern_leds = (busy || !input_led_pattern) ? mem_rd : pattern;

  assign tick_last  = (timer == T_LAST);
  assign last_entry = ({1'b0, i} == (n - N_ONE));
  assign start_play = (state == IDLE) && play_start && (n != '0);
  assign write_ok   = write_pattern && !seq_full && valid_input && !busy && !restart;

  // Playback state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Playback next-state logic; restart always returns to IDLE.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    if (restart) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (play_start) state_nxt = (n == '0) ? DONE : PLAY;
        PLAY: if (tick_last && last_entry) state_nxt = DONE;
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Playback outputs decoded from the current state.
  always_comb begin
    busy      = (state == PLAY);
    play_done = (state == DONE);
  end

  // Sequence length, index, playback timer and latched difficulty.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      n       <= '0;
      i       <= '0;
      timer   <= '0;
      level_q <= 1'b0;
    end else if (restart) begin
      n       <= '0;
      i       <= '0;
      timer   <= '0;
      level_q <= level;
    end else if (busy) begin
      if (tick_last) begin
        timer <= '0;
        i     <= last_entry ? '0 : i + I_ONE;
      end else begin
        timer <= timer + T_ONE;
      end
    end else begin
      if (clear_i)          i <= '0;
      else if (increment_i) i <= i + I_ONE;
      if (write_ok)         n <= n + N_ONE;
      // Entering playback overrides any same-cycle index command.
      if (start_play) begin
        i     <= '0;
        timer <= '0;
      end
    end
  end

  // Pattern memory: synchronous append at address n.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this memory is reset on purpose (LEDs must read 0 after reset), so it maps to flops, not RAM.
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (write_ok) begin
      mem[n[ADDR_W-1:0]] <= pattern;
    end
  end

`ifdef SIMON_SEQ_SCORE_EN
  logic [ADDR_W:0] best_q;

  // High score: longest sequence seen, survives restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_q <= '0;
    end else if (restart) begin
      if (n > best_q) best_q <= n;
    end else if (write_ok) begin
      if ((n + N_ONE) > best_q) best_q <= n + N_ONE;
    end
  end

  assign best_len = best_q;
`else
  assign best_len = '0;
`endif

endmodule
